// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready flow control.
// The carry chain is split into STAGES equal chunks and resolved LSB chunk first.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int L     = STAGES - 1;

    logic [STAGES-1:0] v_q, c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic              ovf_q, zero_q;

    logic [STAGES-1:0] v_d, c_d;
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              ovf_d, zero_d;
    logic              adv;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK =
            WIDTH'({CHUNK{1'b1}}) << (s * CHUNK);

        logic [WIDTH-1:0] a_i, b_i, r_i;
        logic             c_i, v_i;
        logic [CHUNK:0]   sum;

        if (s == 0) begin : g_in
            assign a_i = op1;
            assign b_i = op2 ^ {WIDTH{sub}};
            assign c_i = sub;
            assign r_i = '0;
            assign v_i = in_valid && in_ready;
        end else begin : g_mid
            assign a_i = a_q[s-1];
            assign b_i = b_q[s-1];
            assign c_i = c_q[s-1];
            assign r_i = r_q[s-1];
            assign v_i = v_q[s-1];
        end

        assign sum = {1'b0, a_i[s*CHUNK +: CHUNK]}
                   + {1'b0, b_i[s*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_i};

        assign a_d[s] = a_i;
        assign b_d[s] = b_i;
        assign c_d[s] = sum[CHUNK];
        assign v_d[s] = v_i;
        assign r_d[s] = (r_i & ~MASK)
                      | (WIDTH'(sum[CHUNK-1:0]) << (s * CHUNK));
    end

    assign ovf_d  = (a_d[L][WIDTH-1] == b_d[L][WIDTH-1])
                 && (r_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
    assign zero_d = ~|r_d[L];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            r_q    <= '{default: '0};
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
        end
    end

    assign out_valid = v_q[L];
    assign result    = r_q[L];
    assign carry     = c_q[L];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed cases on a 16/2 instance plus a random
// scoreboard sweep over several width/depth combinations.
module tb_pipe_addsub;
    localparam int NI = 5;

    function automatic int wd(input int i);
        case (i)
            3:       return 32;
            4:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int st(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            4:       return 8;
            default: return 4;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b1;
    logic              sub = 1'b0;
    logic              out_ready = 1'b1;
    logic [31:0]       op1 = 32'd123;
    logic [31:0]       op2 = 32'd1;
    wire  [NI-1:0]     in_rdy, o_v, cy, ov, zr;
    wire  [NI-1:0][31:0] res;

    int checks = 0;
    int errors = 0;
    logic [34:0] sb [NI][$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int W = wd(i);
        pipe_addsub #(.WIDTH(W), .STAGES(st(i))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_rdy[i]),
            .op1      (op1[W-1:0]),
            .op2      (op2[W-1:0]),
            .sub      (sub),
            .out_valid(o_v[i]),
            .out_ready(out_ready),
            .result   (res[i][W-1:0]),
            .carry    (cy[i]),
            .overflow (ov[i]),
            .zero     (zr[i])
        );
        if (W < 32) begin : g_pad
            assign res[i][31:W] = '0;
        end
    end

    // Reference: plain integer arithmetic on the unsigned and signed values.
    function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        longint m, ua, ub, sa, sb2, u, sg, r;
        logic c, o;
        m   = longint'(1) << w;
        ua  = longint'(a) & (m - 1);
        ub  = longint'(b) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb2 = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            u = ua - ub; sg = sa - sb2; c = (ua >= ub);
        end else begin
            u = ua + ub; sg = sa + sb2; c = (u >= m);
        end
        r = u & (m - 1);
        o = (sg < -(m / 2)) || (sg >= m / 2);
        return {(r == 0), o, c, r[31:0]};
    endfunction

    task automatic send_get(input logic [31:0] a, input logic [31:0] b,
                            input logic s, output logic [31:0] r,
                            output logic [2:0] f, output int lat);
        @(negedge clk);
        op1 = a; op2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!o_v[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = res[0];
        f = {cy[0], ov[0], zr[0]};
    endtask

    task automatic test_reset();
        int spur;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_v[0], res[0], cy[0], ov[0], zr[0]} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%0h c=%b o=%b z=%b want all 0",
                     o_v[0], res[0], cy[0], ov[0], zr[0]);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_rdy[0]);
        end
        spur = 0;
        repeat (6) begin
            if (o_v[0] !== 1'b0) spur++;
            @(negedge clk);
        end
        checks++;
        if (spur != 0) begin
            errors++;
            $display("FAIL reset_spurious: got %0d valid cycles want 0", spur);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [2:0] f; int lat;
        send_get(32'd10, 32'd20, 1'b0, r, f, lat);
        checks++;
        if (r !== 32'd30 || f !== 3'b000) begin
            errors++;
            $display("FAIL add_basic: got r=%0d cvz=%b want r=30 cvz=000", r, f);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL add_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r; logic [2:0] f; int lat;
        send_get(32'hFFFF, 32'h0001, 1'b0, r, f, lat);
        checks++;
        if (r !== 32'h0000 || f !== 3'b101) begin
            errors++;
            $display("FAIL add_wrap: got r=%0h cvz=%b want r=0 cvz=101", r, f);
        end
        send_get(32'h7FFF, 32'h0001, 1'b0, r, f, lat);
        checks++;
        if (r !== 32'h8000 || f !== 3'b010) begin
            errors++;
            $display("FAIL add_ovf: got r=%0h cvz=%b want r=8000 cvz=010", r, f);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] r; logic [2:0] f; int lat;
        send_get(32'd7, 32'd5, 1'b1, r, f, lat);
        checks++;
        if (r !== 32'd2 || f !== 3'b100) begin
            errors++;
            $display("FAIL sub_pos: got r=%0h cvz=%b want r=2 cvz=100", r, f);
        end
        send_get(32'd5, 32'd7, 1'b1, r, f, lat);
        checks++;
        if (r !== 32'hFFFE || f !== 3'b000) begin
            errors++;
            $display("FAIL sub_neg: got r=%0h cvz=%b want r=fffe cvz=000", r, f);
        end
        send_get(32'h8000, 32'd1, 1'b1, r, f, lat);
        checks++;
        if (r !== 32'h7FFF || f !== 3'b110) begin
            errors++;
            $display("FAIL sub_ovf: got r=%0h cvz=%b want r=7fff cvz=110", r, f);
        end
    endtask

    task automatic test_backpressure();
        int sent, got;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 3);
            op1       = 32'(sent + 1);
            op2       = 32'(sent + 1);
            sub       = 1'b0;
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (!out_ready) begin
                checks++;
                if (o_v[0] !== 1'b1 || res[0] !== 32'd2 || in_rdy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b r=%0d rdy=%b want v=1 r=2 rdy=0",
                             o_v[0], res[0], in_rdy[0]);
                end
            end
            if (o_v[0] && out_ready) begin
                checks++;
                if (res[0] !== 32'(2 * (got + 1)) || cyc != 5 + got) begin
                    errors++;
                    $display("FAIL bp_order: got r=%0d at cycle %0d want r=%0d at cycle %0d",
                             res[0], cyc, 2 * (got + 1), 5 + got);
                end
                got++;
            end
            if (in_valid && in_rdy[0]) sent++;
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 3", got);
        end
    endtask

    task automatic test_reset_midstream();
        int seen, spur;
        seen = 0; spur = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op1 = 32'(20 + k); op2 = '0; sub = 1'b0;
            out_ready = 1'b1;
            #1;
            if (o_v[0]) seen++;
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; op1 = 32'd99; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (o_v[0] !== 1'b0 || in_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: got v=%b rdy=%b want v=0 rdy=1",
                     o_v[0], in_rdy[0]);
        end
        repeat (8) begin
            @(negedge clk);
            if (o_v[0] !== 1'b0) spur++;
        end
        checks++;
        if (seen != 2 || spur != 0) begin
            errors++;
            $display("FAIL midrst_flush: got before=%0d after=%0d want before=2 after=0",
                     seen, spur);
        end
    endtask

    task automatic test_sweep();
        logic [34:0] exp_v, got_v;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 2040; cyc++) begin
            @(negedge clk);
            in_valid  = (cyc < 2000) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 2000) || ($urandom_range(0, 9) < 7);
            op1 = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
            op2 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31)
                                              : $urandom;
            sub = $urandom_range(0, 1) == 1;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (o_v[i] && out_ready) begin
                    got_v = {zr[i], ov[i], cy[i], res[i]};
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL sweep_extra inst%0d: got %0h want nothing", i, got_v);
                    end else begin
                        exp_v = sb[i].pop_front();
                        if (got_v !== exp_v) begin
                            errors++;
                            $display("FAIL sweep_data inst%0d: got %0h want %0h",
                                     i, got_v, exp_v);
                        end
                    end
                end
                if (in_valid && in_rdy[i])
                    sb[i].push_back(model(wd(i), op1, op2, sub));
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                errors++;
                $display("FAIL sweep_drain inst%0d: got %0d left want 0", i, sb[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_subtract();
        test_backpressure();
        test_reset_midstream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
